// File: rtl/konwersja_pkg.sv
// konwersja_pkg: shared types and constants for the BCD/binary conversion blocks
package konwersja_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int BCD_BASE      = 10;
    localparam int BCD_MAX_DIGIT = 9;

endpackage

// File: rtl/konwersja_mac10.sv
// konwersja_mac10: one decimal fold step, acc*10 + digit, with overflow and bad-digit flags
module konwersja_mac10
    import konwersja_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH+3:0] acc,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             bad_digit
);

    logic [WIDTH+3:0] sum;

    assign sum       = (acc << 3) + (acc << 1) + {{WIDTH{1'b0}}, digit};
    assign result    = sum[WIDTH-1:0];
    assign overflow  = |sum[WIDTH+3:WIDTH];
    assign bad_digit = digit > 4'(BCD_MAX_DIGIT);

endmodule

// File: rtl/konwersja_odwrotna.sv
// konwersja_odwrotna: sequential BCD-to-binary converter, one digit per clock, MSB digit first
module konwersja_odwrotna
    import konwersja_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [4*DIGITS-1:0]   i_argA,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_result,
    output logic                  o_overflow,
    output logic                  o_err
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t              state;
    logic [4*DIGITS-1:0] operand;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    acc;
    logic                ovf;
    logic                err;
    logic [3:0]          digit;
    logic [WIDTH-1:0]    mac_result;
    logic                mac_ovf;
    logic                mac_bad;

    assign digit = operand[4*cnt +: 4];

    konwersja_mac10 #(.WIDTH(WIDTH)) u_mac (
        .acc       ({4'b0000, acc}),
        .digit     (digit),
        .result    (mac_result),
        .overflow  (mac_ovf),
        .bad_digit (mac_bad)
    );

    // Control FSM: capture operand on start, fold one digit per cycle, flag sticky errors
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            operand <= '0;
            cnt     <= '0;
            acc     <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    operand <= i_argA;
                    acc     <= '0;
                    ovf     <= 1'b0;
                    err     <= 1'b0;
                    cnt     <= CW'(DIGITS - 1);
                    state   <= BUSY;
                end
                BUSY: begin
                    acc <= mac_result;
                    ovf <= ovf | mac_ovf;
                    err <= err | mac_bad;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ready    = (state == IDLE);
    assign o_valid    = (state == DONE);
    assign o_result   = acc;
    assign o_overflow = ovf;
    assign o_err      = err;

endmodule

// File: tb/tb_konwersja_odwrotna.sv
// tb_konwersja_odwrotna: vector table, corner sequences and random checks against a decimal model
module tb_konwersja_odwrotna;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 10;
    localparam int AW     = 4 * DIGITS;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [AW-1:0]    arg = '0;
    logic             ready, valid, ovf, err;
    logic [WIDTH-1:0] result;

    int checks = 0;
    int errors = 0;

    konwersja_odwrotna #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_argA     (arg),
        .o_ready    (ready),
        .o_valid    (valid),
        .o_result   (result),
        .o_overflow (ovf),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] res;
        logic             o;
        logic             e;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain decimal value of the operand, reduced to WIDTH bits
    task automatic model(input logic [AW-1:0] a, output logic [WIDTH-1:0] res,
                         output logic o, output logic e);
        longint unsigned v;
        logic [3:0] nib;
        v = 0;
        e = 1'b0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            nib = a[4*d +: 4];
            v = v * 10 + 64'(nib);
            if (nib > 4'd9) e = 1'b1;
        end
        res = v[WIDTH-1:0];
        o = v > 64'hFFFF_FFFF;
    endtask

    function automatic logic [AW-1:0] rand_bcd();
        logic [AW-1:0] r;
        for (int d = 0; d < DIGITS; d++) r[4*d +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic convert(input logic [AW-1:0] a, input logic [WIDTH-1:0] er,
                           input logic eo, input logic ee, input string tag);
        int n;
        chk({tag, " ready_before"}, ready, 1);
        arg = a;
        start = 1'b1;
        step();
        start = 1'b0;
        arg = AW'({$urandom, $urandom});
        chk({tag, " ready_busy"}, ready, 0);
        n = 1;
        while (!valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, " latency"}, n, DIGITS + 1);
        chk({tag, " result"}, result, er);
        chk({tag, " overflow"}, ovf, eo);
        chk({tag, " err"}, err, ee);
        step();
        chk({tag, " valid_pulse"}, valid, 0);
        chk({tag, " ready_after"}, ready, 1);
        chk({tag, " result_held"}, result, er);
    endtask

    initial begin
        logic [WIDTH-1:0] mr;
        logic mo, me;
        logic [AW-1:0] acc_q[$];
        logic [AW-1:0] a;
        int seen;

        vt[0] = '{40'h00_0000_1234, 32'd1234,        1'b0, 1'b0};
        vt[1] = '{40'h42_9496_7295, 32'hFFFF_FFFF,   1'b0, 1'b0};
        vt[2] = '{40'h42_9496_7296, 32'h0000_0000,   1'b1, 1'b0};
        vt[3] = '{40'h00_0000_00A5, 32'd105,         1'b0, 1'b1};
        vt[4] = '{40'h00_0000_0000, 32'd0,           1'b0, 1'b0};
        vt[5] = '{40'h99_9999_9999, 32'h540B_E3FF,   1'b1, 1'b0};
        vt[6] = '{40'h00_0000_0009, 32'd9,           1'b0, 1'b0};

        #2;
        chk("reset ready", ready, 1);
        chk("reset valid", valid, 0);
        chk("reset result", result, 0);
        chk("reset overflow", ovf, 0);
        chk("reset err", err, 0);
        #10 rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) convert(vt[i].a, vt[i].res, vt[i].o, vt[i].e, $sformatf("vec%0d", i));

        // Asynchronous reset mid-conversion
        arg = 40'h00_0000_5678;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("midrst ready", ready, 1);
        chk("midrst valid", valid, 0);
        chk("midrst result", result, 0);
        step();
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            step();
            if (valid) seen++;
        end
        chk("midrst no_valid", seen, 0);
        convert(40'h00_0000_0099, 32'd99, 1'b0, 1'b0, "after_rst");

        // Reset while flags and partial result are non-zero
        arg = 40'hFF_FFFF_FFFF;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        chk("midrst2 err_set", err, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst2 result", result, 0);
        chk("midrst2 err", err, 0);
        chk("midrst2 overflow", ovf, 0);
        chk("midrst2 ready", ready, 1);
        step();
        rst_n = 1'b1;
        step();

        // Start held high with operand changing every cycle
        start = 1'b1;
        for (int k = 0; k < 3 * (DIGITS + 2); k++) begin
            a = rand_bcd();
            arg = a;
            if (k % (DIGITS + 2) == 0) acc_q.push_back(a);
            step();
            if (k % (DIGITS + 2) == DIGITS) begin
                model(acc_q.pop_front(), mr, mo, me);
                chk($sformatf("held valid k%0d", k), valid, 1);
                chk($sformatf("held result k%0d", k), result, mr);
                chk($sformatf("held overflow k%0d", k), ovf, mo);
            end else begin
                chk($sformatf("held novalid k%0d", k), valid, 0);
            end
        end
        start = 1'b0;
        repeat (DIGITS + 3) step();

        // Random valid BCD operands, then a few with arbitrary nibbles
        for (int i = 0; i < 16; i++) begin
            a = rand_bcd();
            model(a, mr, mo, me);
            convert(a, mr, mo, me, $sformatf("rnd%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            a = AW'({$urandom, $urandom});
            model(a, mr, mo, me);
            convert(a, mr, mo, me, $sformatf("raw%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/konwersja_odwrotna.md
# konwersja_odwrotna

Sequential BCD-to-binary converter for the execution unit: the inverse direction of the unit's binary→BCD conversion path. Accepts a packed BCD operand on a start strobe, folds one decimal digit per clock (MSB digit first) into a binary accumulator, and returns a WIDTH-bit binary result with a one-cycle valid pulse plus overflow and invalid-digit flags.

## Interface
Parameters:
- WIDTH, 32, binary result width
- DIGITS, 10, number of BCD digits in the operand (input is 4*DIGITS bits)

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_start  input  1  start request; sampled only when o_ready=1
- i_argA  input  4*DIGITS  packed BCD operand, digit k at bits [4k+3:4k], digit DIGITS-1 most significant
- o_ready  output  1  block idle, will accept i_start this cycle
- o_valid  output  1  one-cycle pulse, result and flags valid
- o_result  output  WIDTH  binary value, low WIDTH bits of accumulator
- o_overflow  output  1  decimal value exceeded 2^WIDTH-1
- o_err  output  1  at least one digit nibble >9

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: o_ready=1. On i_start=1: capture i_argA into operand register, clear accumulator, o_overflow, o_err, load digit counter DIGITS-1, go BUSY.
- BUSY: each cycle take digit at counter index; acc_next = acc*10 + d, computed as (acc<<3)+(acc<<1)+d. Counter decrements; after digit 0 processed, go DONE.
- DONE: o_valid=1 for exactly this cycle; next edge returns to IDLE.
- Accumulator is WIDTH+4 bits internally; if acc_next >= 2^WIDTH, set o_overflow (sticky for the conversion) and keep only low WIDTH bits in the accumulator before continuing.
- Digit >9: set o_err (sticky); digit value is still accumulated as-is (no saturation, no skip).
- o_result, o_overflow, o_err hold their values from DONE until the next accepted i_start (cleared at acceptance).
- i_start while BUSY or DONE is ignored; operand register does not change while BUSY.
- Unsigned only; no sign digit.

## Timing
- Reset (asynchronous, i_rst_n=0): state IDLE, o_ready=1, o_valid=0, o_result=0, o_overflow=0, o_err=0, counter and operand cleared; takes effect immediately, including mid-conversion, and the aborted conversion produces no o_valid.
- Edge 0 samples i_start; edges 1..DIGITS process digits; o_valid high in the cycle after edge DIGITS; edge DIGITS+1 returns to IDLE.
- Latency: DIGITS+1 cycles from start edge to o_valid (11 for default).
- Throughput: one conversion per DIGITS+2 cycles; earliest new start is sampled at the first IDLE edge after DONE.
- o_ready is low from edge 0 through the DONE cycle inclusive.
- i_argA only needs to be stable in the cycle i_start is sampled.

## Structure
- Shared package konwersja_pkg: state enum (IDLE, BUSY, DONE), constants BCD_BASE=10, BCD_MAX_DIGIT=9; shared with the forward conversion block.
- One combinational sub-module konwersja_mac10: inputs acc (WIDTH+4), digit (4); outputs acc*10+digit, overflow-bit and digit>9 indication. Top holds FSM, counter, operand and flag registers.

## Test plan
Defaults WIDTH=32, DIGITS=10.
- i_argA=40'h00_0000_1234, i_start pulse -> o_valid exactly 11 cycles later, o_result=32'd1234 (0x4D2), o_overflow=0, o_err=0.
- i_argA=40'h42_9496_7295 -> o_result=32'hFFFF_FFFF, o_overflow=0, o_err=0.
- i_argA=40'h42_9496_7296 -> o_overflow=1, o_result=32'h0000_0000, o_err=0.
- i_argA=40'h00_0000_00A5 -> o_err=1, o_result=32'd105, o_overflow=0.
- Start 40'h00_0000_5678, drop i_rst_n 5 cycles in -> all outputs 0 immediately, o_ready=1, no o_valid; after release, start 40'h00_0000_0099 -> o_result=32'd99.
- i_start held high continuously with i_argA changing every cycle -> only IDLE-cycle values accepted, one o_valid per DIGITS+2 cycles, results match operands captured at acceptance; plus 16 random valid-BCD operands checked against a reference decimal model.
